seven_seg_display_ctrl: RTL and testbench
=========================================

# seven_seg_display_ctrl

Sequential controller that owns the board's 4-digit seven-segment display. It accepts a 13-bit binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3, one iteration per clock. It then latches the four digits and time-multiplexes them onto common-anode displays using a refresh counter. It sits between the core's MMIO/debug output register and the board pins.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  13  unsigned binary value, 0–8191.
- in_ready  output  1  controller can accept a value; high only in IDLE.
- busy  output  1  conversion in progress; equals ~in_ready.
- anode  output  4  active-low digit enables; bit 0 = ones … bit 3 = thousands.
- segments  output  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Conversion FSM states are IDLE and CONVERT.
- IDLE: on in_valid & in_ready, the controller captures in_data into a 13-bit shift register, clears the working BCD registers and the iteration count, and moves to CONVERT.
- CONVERT: each cycle performs one iteration, MSB first.
  - Adjust: any working nibble ≥5 gets +3.
  - Shift: the whole {thousands, hundreds, tens, ones, shift_reg} chain shifts left one bit.
  - The iteration that brings the count to 13 writes the shifted nibbles into the display digit registers and returns to IDLE.
- Nibbles are 4 bits. With a maximum input of 8191, no nibble overflows and no thousands carry is produced.
- in_valid while busy is ignored; there is no queuing.
- Display scan:
  - A free-running counter counts 0..REFRESH_DIV-1. The tick fires when it wraps.
  - On each tick, the digit index advances 0→1→2→3→0, and anode/segments are registered from the current display digit registers.
  - Scanning is independent of the FSM. A new value appears position by position, on the ticks following the update.
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Reset values:
  - FSM IDLE, in_ready=1, busy=0.
  - Display digits 0, digit index 3, refresh counter 0.
  - anode=4'b1111, segments=7'b1111111.

## Timing
- Value accepted at edge N. Iterations occur at edges N+1..N+13, and the display digits update at edge N+13.
- in_ready is low for exactly 13 cycles and high again in the cycle after edge N+13. This gives a back-to-back throughput of one value per 14 cycles.
- The first tick occurs REFRESH_DIV cycles after reset release and shows digit 0 (anode=1110). Each digit is then held for REFRESH_DIV cycles.
- With REFRESH_DIV=1, the tick fires every cycle.
- Reset mid-conversion: the conversion is aborted, the display digits return to 0000, and in_ready=1 in the cycle after the reset edge.
- A tick coinciding with the final iteration registers the old digit value. The new value is visible from the next tick.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a digit position is blanked (anode bit 1, segments 1111111) when it and every higher digit are zero. Ones is never blanked. Blanking is evaluated at tick time from the display digit registers.
- LEADING_ZERO_BLANK_EN undefined: all four positions are always driven, with leading zeros shown.

## Structure
- Package seg_pkg holds:
  - IN_W=13, NUM_DIGITS=4, BCD_ITERS=13.
  - The ten digit segment constants and SEG_BLANK.
  - The FSM state typedef (IDLE, CONVERT).
- Sub-module bcd_iter_step is one combinational double-dabble iteration: adjust ≥5 by +3, then shift in one bit. The controller instantiates it once and feeds it from the working registers each cycle.

## Test plan
- Reset, then hold for 3 cycles (REFRESH_DIV=4) → anode=1111, segments=1111111, in_ready=1, busy=0. At the first tick, anode=1110 with segments=1000000.
- Load 1234 (REFRESH_DIV=4) → in_ready low for exactly 13 cycles, then the scan shows:
  - anode 1110 → 0011001
  - anode 1101 → 0110000
  - anode 1011 → 0100100
  - anode 0111 → 1111001
- Load 8191 → digits 8,1,9,1. Load 0 → 0000 without LEADING_ZERO_BLANK_EN.
- Load 4321, then pulse in_valid with 5 at cycle 6 of CONVERT → the second value is ignored and the display settles to 4321.
- Assert rst at iteration 6 of a 999 conversion → in_ready=1 next cycle, display 0000, anode=1111 until the first tick.
- With LEADING_ZERO_BLANK_EN, load 7 → the ones slot shows 1111000 and the other three slots show anode bit 1 and 1111111. Load 1005 → all four slots are driven (1,0,0,5).

Source files
------------

// File: rtl/seven_seg_display_ctrl_pkg.sv
// Shared constants, segment codes and FSM state for the 7-seg controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int IN_W       = 13;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_ITERS  = 13;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_bcd_iter_step.sv
// One combinational double-dabble iteration: nibbles >=5 get +3, then shift.
// Ports: bcd_in (working BCD), bit_in (next binary MSB), bcd_out.
module bcd_iter_step
  import seg_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bit_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  logic [4*NUM_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    bcd_out = {adj[4*NUM_DIGITS-2:0], bit_in};
  end

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// 13-bit binary to 4-digit BCD converter plus multiplexed 7-seg scanner.
// Ports: clk, rst (sync, high), in_valid/in_data/in_ready, busy, anode, segments.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic            busy,
  output logic [3:0]      anode,
  output logic [6:0]      segments
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RMAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST = 4'(BCD_ITERS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [IN_W-1:0] shreg;
  logic [DW-1:0]   bcd;
  logic [DW-1:0]   bcd_nxt;
  logic [DW-1:0]   disp;
  logic [3:0]      cnt;
  logic            accept;
  logic            last;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;
  assign last     = (state_q == CONVERT) && (cnt == LAST);

  bcd_iter_step u_step (
    .bcd_in  (bcd),
    .bit_in  (shreg[IN_W-1]),
    .bcd_out (bcd_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      disp  <= '0;
    end else if (accept) begin
      shreg <= in_data;
      bcd   <= '0;
      cnt   <= '0;
    end else if (state_q == CONVERT) begin
      shreg <= shreg << 1;
      bcd   <= bcd_nxt;
      cnt   <= cnt + 4'd1;
      if (last) disp <= bcd_nxt;
    end
  end

  logic [CW-1:0] rcnt;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic          tick;
  logic [3:0]    anode_n;
  logic [6:0]    seg_n;

  assign tick  = (rcnt == RMAX);
  assign idx_n = idx + 2'd1;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  hz;

  // lz[p]: digit p and all higher digits are zero; ones always shown
  always_comb begin
    hz = 1'b1;
    lz = '0;
    for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
      hz    = hz & (disp[4*p +: 4] == 4'd0);
      lz[p] = hz;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    anode_n = ~(4'b0001 << idx_n);
    seg_n   = seg_encode(disp[4*idx_n +: 4]);
    if (lz[idx_n]) begin
      anode_n = 4'b1111;
      seg_n   = SEG_BLANK;
    end
  end
`else
  always_comb begin
    anode_n = ~(4'b0001 << idx_n);
    seg_n   = seg_encode(disp[4*idx_n +: 4]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      idx      <= 2'd3;
      anode    <= 4'b1111;
      segments <= SEG_BLANK;
    end else begin
      rcnt <= tick ? '0 : rcnt + 1'b1;
      if (tick) begin
        idx      <= idx_n;
        anode    <= anode_n;
        segments <= seg_n;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl with REFRESH_DIV=4.
// Expected scan slots are queued at load time and popped as slots appear.
module tb_seven_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] in_data;
  logic        in_ready;
  logic        busy;
  logic [3:0]  anode;
  logic [6:0]  segments;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int pw [4] = '{1, 10, 100, 1000};

  always #5 clk = ~clk;

  seven_seg_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .anode    (anode),
    .segments (segments)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_slot(input int v, input int p);
    logic [3:0] an;
    logic [6:0] sg;
    an = 4'b1111;
    an[p] = 1'b0;
    sg = segtab[(v / pw[p]) % 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (p > 0 && v < pw[p]) begin
      an = 4'b1111;
      sg = 7'b1111111;
    end
`endif
    return {an, sg};
  endfunction

  task automatic push_scan(input int v);
    for (int p = 0; p < 4; p++) sb.push_back(exp_slot(v, p));
  endtask

  task automatic drain_scan(input string tag);
    int n;
    logic ok;
    n = 0;
    while (anode == 4'b1110 && n < 40) begin step(); n++; end
    while (anode != 4'b1110 && n < 40) begin step(); n++; end
    ok = (n < 40);
    chk({tag, "_sync"}, 32'(ok), 32'd1);
    for (int p = 0; p < 4; p++) begin
      logic [10:0] e;
      e = sb.pop_front();
      chk($sformatf("%s_slot%0d", tag, p), 32'({anode, segments}), 32'(e));
      if (p < 3) repeat (4) step();
    end
  endtask

  task automatic accept(input int v);
    in_data  = 13'(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!in_ready && n < 50) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      step();
      n++;
    end
  endtask

  task automatic load(input int v, input string tag);
    int n;
    accept(v);
    wait_ready(tag, n);
    chk({tag, "_lowcyc"}, 32'(n), 32'd13);
    push_scan(v);
    drain_scan(tag);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_anode", 32'(anode), 32'hF);
      chk("rst_seg", 32'(segments), 32'h7F);
    end
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    sb.push_back(exp_slot(0, 0));
    chk("first_tick", 32'({anode, segments}), 32'(sb.pop_front()));

    load(1234, "v1234");
    load(8191, "v8191");
    load(0, "v0");

    accept(4321);
    repeat (5) step();
    in_data  = 13'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ign_busy", 32'(in_ready), 32'd0);
    wait_ready("ign", n);
    chk("ign_lowcyc", 32'(n), 32'd7);
    step();
    chk("ign_noreload", 32'(in_ready), 32'd1);
    push_scan(4321);
    drain_scan("v4321");

    accept(999);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_anode", 32'(anode), 32'hF);
    push_scan(0);
    drain_scan("abort");

`ifdef LEADING_ZERO_BLANK_EN
    load(7, "lz7");
    load(1005, "lz1005");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
